// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat hand datapath: card encoding,
// slot and order-tracker enumerations, error codes and card valuation.
package baccarat_pkg;

    typedef logic [3:0] card_t;

    localparam card_t RANK_MIN = 4'd1;
    localparam card_t RANK_MAX = 4'd13;
    localparam int    NUM_SLOTS = 6;

    // Slot index doubles as the bit position of its load strobe.
    typedef enum logic [2:0] {
        SLOT_P1 = 3'd0,
        SLOT_D1 = 3'd1,
        SLOT_P2 = 3'd2,
        SLOT_D2 = 3'd3,
        SLOT_P3 = 3'd4,
        SLOT_D3 = 3'd5
    } slot_e;

    // Order tracker: names the last slot that was filled.
    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_P1    = 3'd1,
        ST_D1    = 3'd2,
        ST_P2    = 3'd3,
        ST_D2    = 3'd4,
        ST_P3    = 3'd5,
        ST_D3    = 3'd6
    } order_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_MULTI   = 2'd1,
        ERR_ORDER   = 2'd2,
        ERR_BADCARD = 2'd3
    } err_t;

    // Baccarat value of a rank: 1..9 at face value, tens/faces/empty are 0.
    function automatic logic [3:0] card_value(input card_t card);
        logic [3:0] val;
        if ((card >= RANK_MIN) && (card <= 4'd9)) begin
            val = card;
        end else begin
            val = 4'd0;
        end
        return val;
    endfunction

endpackage

// File: rtl/card_scorer.sv
// Combinational baccarat score of a three-card hand: sum of card values mod 10.
module card_scorer
    import baccarat_pkg::*;
(
    input  card_t      card1,
    input  card_t      card2,
    input  card_t      card3,
    output logic [3:0] score
);

    logic [4:0] sum_s;

    // Raw sum is at most 27, so at most two subtractions of 10 are needed.
    always_comb begin
        sum_s = {1'b0, card_value(card1)} + {1'b0, card_value(card2)}
              + {1'b0, card_value(card3)};
        if (sum_s >= 5'd20) begin
            score = 4'(sum_s - 5'd20);
        end else if (sum_s >= 5'd10) begin
            score = 4'(sum_s - 5'd10);
        end else begin
            score = sum_s[3:0];
        end
    end

endmodule

// File: rtl/hand_datapath.sv
// Card-dealing datapath: latches dealt cards into player/dealer slots,
// enforces the deal order and reports protocol violations (sticky).
module hand_datapath
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] new_card,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [2:0] cards_dealt,
    output logic       proto_err,
    output logic [1:0] err_code
);

    logic [NUM_SLOTS-1:0][3:0] cards_q, cards_d;
    order_e                    state_q, state_d;
    logic [2:0]                cards_dealt_q, cards_dealt_d;
    logic                      proto_err_q, proto_err_d;
    err_t                      err_code_q, err_code_d;

    logic [NUM_SLOTS-1:0]      strobe_s;
    logic [NUM_SLOTS-1:0]      allowed_s;
    logic                      multi_s;
    logic                      legal_s;
    logic                      card_ok_s;

    assign strobe_s = {load_dcard3, load_pcard3, load_dcard2,
                       load_pcard2, load_dcard1, load_pcard1};

    // Slots that may legally be loaded next, given the last slot filled.
    always_comb begin
        allowed_s = 6'b000000;
        case (state_q)
            ST_EMPTY: allowed_s = 6'b000001;
            ST_P1:    allowed_s = 6'b000010;
            ST_D1:    allowed_s = 6'b000100;
            ST_P2:    allowed_s = 6'b001000;
            ST_D2:    allowed_s = 6'b110000;
            ST_P3:    allowed_s = 6'b100000;
            ST_D3:    allowed_s = 6'b000000;
            default:  allowed_s = 6'b000000;
        endcase
    end

    // Strobe classification: more than one bit set is MULTI.
    always_comb begin
        multi_s   = ((strobe_s & (strobe_s - 6'd1)) != 6'd0);
        legal_s   = (!multi_s) && ((strobe_s & allowed_s) != 6'd0);
        card_ok_s = (new_card >= RANK_MIN) && (new_card <= RANK_MAX);
    end

    // Next-state: load on a legal strobe with a valid rank, else flag the error.
    always_comb begin
        cards_d       = cards_q;
        state_d       = state_q;
        cards_dealt_d = cards_dealt_q;
        proto_err_d   = proto_err_q;
        err_code_d    = err_code_q;
        if (strobe_s == 6'd0) begin
            cards_d = cards_q;
        end else if (multi_s) begin
            proto_err_d = 1'b1;
            if (err_code_q == ERR_NONE) begin
                err_code_d = ERR_MULTI;
            end else begin
                err_code_d = err_code_q;
            end
        end else if (!legal_s) begin
            proto_err_d = 1'b1;
            if (err_code_q == ERR_NONE) begin
                err_code_d = ERR_ORDER;
            end else begin
                err_code_d = err_code_q;
            end
        end else if (!card_ok_s) begin
            proto_err_d = 1'b1;
            if (err_code_q == ERR_NONE) begin
                err_code_d = ERR_BADCARD;
            end else begin
                err_code_d = err_code_q;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (strobe_s[i]) begin
                    cards_d[i] = new_card;
                end else begin
                    cards_d[i] = cards_q[i];
                end
            end
            cards_dealt_d = cards_dealt_q + 3'd1;
            case (strobe_s)
                6'b000001: state_d = ST_P1;
                6'b000010: state_d = ST_D1;
                6'b000100: state_d = ST_P2;
                6'b001000: state_d = ST_D2;
                6'b010000: state_d = ST_P3;
                6'b100000: state_d = ST_D3;
                default:   state_d = state_q;
            endcase
        end
    end

    // State registers; reset clears the hand and the error record.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            cards_q       <= '0;
            state_q       <= ST_EMPTY;
            cards_dealt_q <= 3'd0;
            proto_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            cards_q       <= cards_d;
            state_q       <= state_d;
            cards_dealt_q <= cards_dealt_d;
            proto_err_q   <= proto_err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign pcard1      = cards_q[SLOT_P1];
    assign dcard1      = cards_q[SLOT_D1];
    assign pcard2      = cards_q[SLOT_P2];
    assign dcard2      = cards_q[SLOT_D2];
    assign pcard3      = cards_q[SLOT_P3];
    assign dcard3      = cards_q[SLOT_D3];
    assign cards_dealt = cards_dealt_q;
    assign proto_err   = proto_err_q;
    assign err_code    = err_code_q;

    card_scorer u_player_scorer (
        .card1 (cards_q[SLOT_P1]),
        .card2 (cards_q[SLOT_P2]),
        .card3 (cards_q[SLOT_P3]),
        .score (pscore)
    );

    card_scorer u_dealer_scorer (
        .card1 (cards_q[SLOT_D1]),
        .card2 (cards_q[SLOT_D2]),
        .card3 (cards_q[SLOT_D3]),
        .score (dscore)
    );

endmodule

// File: tb/tb_hand_datapath.sv
// Self-checking bench for hand_datapath: directed deal scenarios followed by
// randomized strobes/cards, all compared against a behavioural hand model.
module tb_hand_datapath;

    logic       slow_clock;
    logic       resetb;
    logic [3:0] new_card;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic [2:0] cards_dealt;
    logic       proto_err;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: slot order p1,d1,p2,d2,p3,d3; 0 means empty.
    int m_card[6];
    int m_perr;
    int m_ecode;

    // Mask bit positions used by the stimulus.
    localparam logic [5:0] M_P1 = 6'b000001;
    localparam logic [5:0] M_D1 = 6'b000010;
    localparam logic [5:0] M_P2 = 6'b000100;
    localparam logic [5:0] M_D2 = 6'b001000;
    localparam logic [5:0] M_P3 = 6'b010000;
    localparam logic [5:0] M_D3 = 6'b100000;

    hand_datapath dut (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .new_card    (new_card),
        .load_pcard1 (load_pcard1),
        .load_pcard2 (load_pcard2),
        .load_pcard3 (load_pcard3),
        .load_dcard1 (load_dcard1),
        .load_dcard2 (load_dcard2),
        .load_dcard3 (load_dcard3),
        .pcard1      (pcard1),
        .pcard2      (pcard2),
        .pcard3      (pcard3),
        .dcard1      (dcard1),
        .dcard2      (dcard2),
        .dcard3      (dcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .cards_dealt (cards_dealt),
        .proto_err   (proto_err),
        .err_code    (err_code)
    );

    // Free-running dealing clock.
    initial begin
        slow_clock = 1'b0;
        forever #5 slow_clock = ~slow_clock;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_value(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int m_score(input int a, input int b, input int c);
        return (m_value(a) + m_value(b) + m_value(c)) % 10;
    endfunction

    // Deal-order rule stated as prerequisites on which slots are already filled.
    function automatic bit m_legal(input int idx);
        bit f[6];
        for (int i = 0; i < 6; i++) f[i] = (m_card[i] != 0);
        case (idx)
            0: return !f[0];
            1: return f[0] && !f[1];
            2: return f[1] && !f[2];
            3: return f[2] && !f[3];
            4: return f[3] && !f[4] && !f[5];
            5: return f[3] && !f[5];
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 6; i++) m_card[i] = 0;
        m_perr  = 0;
        m_ecode = 0;
    endtask

    task automatic m_error(input int code);
        m_perr = 1;
        if (m_ecode == 0) m_ecode = code;
    endtask

    task automatic m_apply(input logic [5:0] mask, input int card);
        int n;
        int idx;
        n   = $countones(mask);
        idx = 0;
        for (int i = 0; i < 6; i++) if (mask[i]) idx = i;
        if (n == 0) begin
        end else if (n > 1) begin
            m_error(1);
        end else if (!m_legal(idx)) begin
            m_error(2);
        end else if (card < 1 || card > 13) begin
            m_error(3);
        end else begin
            m_card[idx] = card;
        end
    endtask

    task automatic check_all(input string tag);
        int dealt;
        dealt = 0;
        for (int i = 0; i < 6; i++) if (m_card[i] != 0) dealt++;
        check_eq({tag, ".pcard1"}, pcard1, m_card[0]);
        check_eq({tag, ".dcard1"}, dcard1, m_card[1]);
        check_eq({tag, ".pcard2"}, pcard2, m_card[2]);
        check_eq({tag, ".dcard2"}, dcard2, m_card[3]);
        check_eq({tag, ".pcard3"}, pcard3, m_card[4]);
        check_eq({tag, ".dcard3"}, dcard3, m_card[5]);
        check_eq({tag, ".pscore"}, pscore, m_score(m_card[0], m_card[2], m_card[4]));
        check_eq({tag, ".dscore"}, dscore, m_score(m_card[1], m_card[3], m_card[5]));
        check_eq({tag, ".dealt"}, cards_dealt, dealt);
        check_eq({tag, ".perr"}, proto_err, m_perr);
        check_eq({tag, ".ecode"}, err_code, m_ecode);
    endtask

    task automatic drive(input logic [5:0] mask);
        {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1} = mask;
    endtask

    // One dealing cycle: drive at negedge, sample just after the rising edge.
    task automatic step(input string tag, input logic [5:0] mask, input int card);
        @(negedge slow_clock);
        drive(mask);
        new_card = 4'(card);
        @(posedge slow_clock);
        #1;
        m_apply(mask, card);
        drive(6'b000000);
        new_card = 4'($urandom_range(0, 15));
        check_all(tag);
    endtask

    // Asynchronous reset between edges, with a strobe present to show dominance.
    task automatic async_reset(input string tag);
        @(negedge slow_clock);
        #2;
        drive(M_P1);
        new_card = 4'd5;
        resetb = 1'b0;
        #1;
        m_reset();
        check_all({tag, ".async"});
        @(posedge slow_clock);
        #1;
        check_all({tag, ".held"});
        @(negedge slow_clock);
        drive(6'b000000);
        resetb = 1'b1;
    endtask

    task automatic deal4(input string tag, input int a, input int b, input int c, input int d);
        step({tag, ".p1"}, M_P1, a);
        step({tag, ".d1"}, M_D1, b);
        step({tag, ".p2"}, M_P2, c);
        step({tag, ".d2"}, M_D2, d);
    endtask

    initial begin
        logic [5:0] mask;
        int         r;
        resetb   = 1'b0;
        new_card = 4'd0;
        drive(6'b000000);
        m_reset();
        #12;
        check_all("reset");
        @(negedge slow_clock);
        resetb = 1'b1;

        // Normal deal of four cards.
        deal4("normal", 7, 3, 12, 5);
        check_eq("normal.pscore_abs", pscore, 7);
        check_eq("normal.dscore_abs", dscore, 8);
        check_eq("normal.dealt_abs", cards_dealt, 4);

        // Both third cards.
        async_reset("r1");
        deal4("third", 4, 9, 13, 2);
        step("third.p3", M_P3, 6);
        step("third.d3", M_D3, 10);
        check_eq("third.pscore_abs", pscore, 0);
        check_eq("third.dscore_abs", dscore, 1);
        check_eq("third.pcard3_abs", pcard3, 6);
        check_eq("third.dealt_abs", cards_dealt, 6);
        step("third.extra", M_P1, 3);
        check_eq("third.order_abs", err_code, 2);

        // Wrap-around of the player sum.
        async_reset("r2");
        deal4("wrap", 8, 7, 9, 6);
        check_eq("wrap.pscore_abs", pscore, 7);

        // Dealer draws without a player third card; late p3 is an order error.
        step("skip.d3", M_D3, 1);
        check_eq("skip.dcard3_abs", dcard3, 1);
        check_eq("skip.pcard3_abs", pcard3, 0);
        step("skip.p3", M_P3, 4);
        check_eq("skip.ecode_abs", err_code, 2);

        // Simultaneous strobes, then a bad rank on a legal strobe.
        async_reset("r3");
        step("multi", M_P1 | M_D1, 4);
        check_eq("multi.ecode_abs", err_code, 1);
        step("bad.p1", M_P1, 14);
        check_eq("bad.ecode_abs", err_code, 1);
        check_eq("bad.pcard1_abs", pcard1, 0);
        step("bad.zero", M_P1, 0);

        // Out-of-order and duplicate loads.
        async_reset("r4");
        step("order.d1", M_D1, 3);
        check_eq("order.ecode_abs", err_code, 2);
        async_reset("r5");
        step("dup.p1", M_P1, 9);
        step("dup.p1again", M_P1, 2);
        check_eq("dup.pcard1_abs", pcard1, 9);

        // Reset mid-hand, then a fresh deal.
        async_reset("r6");
        step("mid.p1", M_P1, 11);
        step("mid.d1", M_D1, 6);
        step("mid.p2", M_P2, 3);
        async_reset("mid");
        step("mid.after", M_P1, 1);
        check_eq("mid.dealt_abs", cards_dealt, 1);
        check_eq("mid.pcard1_abs", pcard1, 1);

        // Randomized strobes and ranks, with periodic resets.
        for (int k = 0; k < 400; k++) begin
            if ((k % 14) == 13) begin
                async_reset("rnd_rst");
            end else begin
                r = $urandom_range(0, 11);
                if (r == 0) begin
                    mask = 6'b000000;
                end else if (r == 1) begin
                    mask = 6'b000000;
                    mask[$urandom_range(0, 5)] = 1'b1;
                    mask[$urandom_range(0, 5)] = 1'b1;
                end else begin
                    mask = 6'b000000;
                    mask[$urandom_range(0, 5)] = 1'b1;
                end
                step("rnd", mask, (r == 2) ? $urandom_range(0, 15) : $urandom_range(1, 13));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
